clk_div_monitor: RTL

Frequency and duty-cycle monitor for divided clocks, placed directly downstream of the odd/even clock dividers. It samples a divided clock (`div_in`) in the source `clk` domain and measures high time, low time and period in `clk` cycles. It checks each period against a configured expectation, asserts `locked` after a run of good periods, and reports period, duty and stuck-clock faults.

---
 rtl/clk_div_monitor.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: period, duty and stuck-clock monitor for a divided clock.
// Optional duty-cycle check enabled by defining MON_DUTY_CHECK_EN.

module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 5,
    parameter int PER_TOL    = 0,
    parameter int DUTY_TOL   = 1,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             meas_vld,
    output logic             locked,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic             err_sticky
);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   wide_t;
    typedef logic [3:0]       lock_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_e;

    localparam cnt_t  ONE    = cnt_t'(1);
    localparam cnt_t  TO_N   = cnt_t'(TIMEOUT);
    localparam cnt_t  DUTY_N = cnt_t'(DUTY_TOL);
    localparam wide_t EXP_W  = wide_t'(EXP_PERIOD);
    localparam wide_t PTOL_W = wide_t'(PER_TOL);
    localparam lock_t LOCK_N = lock_t'(LOCK_CNT);

`ifdef MON_DUTY_CHECK_EN
    localparam bit DUTY_EN = 1'b1;
`else
    // Duty comparator is tied off; its result never reaches the fault logic.
    localparam bit DUTY_EN = 1'b0;
`endif

    logic   s1_q, s2_q, s3_q, rise_q;
    state_e state_q, state_d;
    cnt_t   hi_q, hi_d;
    cnt_t   lo_q, lo_d;
    cnt_t   per_q, per_d;
    cnt_t   high_q, high_d;
    cnt_t   low_q, low_d;
    logic   vld_q, vld_d;
    logic   locked_q, locked_d;
    lock_t  lock_q, lock_d;
    lock_t  lock_inc;
    logic   perr_q, perr_d;
    logic [1:0] code_q, code_d;
    logic   sticky_q, sticky_d;

    wide_t  sum;
    wide_t  per_dev;
    cnt_t   per_sat;
    cnt_t   duty_dev;
    logic   per_bad;
    logic   duty_bad;
    logic   fault;
    logic   good;
    logic [1:0] fcode;

    // FSM runs one cycle behind the edge detector: s3 is the level that
    // lines up with the registered rise strobe.
    assign sum      = wide_t'(hi_q) + wide_t'(lo_q);
    assign per_sat  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    assign per_dev  = (sum >= EXP_W) ? (sum - EXP_W) : (EXP_W - sum);
    assign per_bad  = sum[CNT_W] | (per_dev > PTOL_W);
    assign duty_dev = (hi_q >= lo_q) ? (hi_q - lo_q) : (lo_q - hi_q);
    assign duty_bad = DUTY_EN & (duty_dev > DUTY_N);
    assign lock_inc = (lock_q == LOCK_N) ? lock_q : lock_q + lock_t'(1);

    // Two-flop synchronizer, third flop and registered rise strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= div_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
        end
    end

    // Next-state: level counting, publication, checks and lock tracking
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        per_d    = per_q;
        high_d   = high_q;
        low_d    = low_q;
        vld_d    = 1'b0;
        perr_d   = 1'b0;
        code_d   = code_q;
        sticky_d = sticky_q;
        lock_d   = lock_q;
        locked_d = locked_q;
        fault    = 1'b0;
        good     = 1'b0;
        fcode    = 2'd0;

        unique case (state_q)
            S_IDLE: begin
                hi_d = '0;
                lo_d = '0;
                if (rise_q) begin
                    state_d = S_HIGH;
                    hi_d    = ONE;
                end
            end
            S_HIGH: begin
                if (hi_q == TO_N) begin
                    fault   = 1'b1;
                    fcode   = 2'd3;
                    state_d = S_IDLE;
                    hi_d    = '0;
                    lo_d    = '0;
                end else if (s3_q) begin
                    hi_d = hi_q + ONE;
                end else begin
                    state_d = S_LOW;
                    lo_d    = ONE;
                end
            end
            S_LOW: begin
                if (lo_q == TO_N) begin
                    fault   = 1'b1;
                    fcode   = 2'd3;
                    state_d = S_IDLE;
                    hi_d    = '0;
                    lo_d    = '0;
                end else if (rise_q) begin
                    per_d   = per_sat;
                    high_d  = hi_q;
                    low_d   = lo_q;
                    vld_d   = 1'b1;
                    state_d = S_HIGH;
                    hi_d    = ONE;
                    lo_d    = '0;
                    if (per_bad) begin
                        fault = 1'b1;
                        fcode = 2'd1;
                    end else if (duty_bad) begin
                        fault = 1'b1;
                        fcode = 2'd2;
                    end else begin
                        good = 1'b1;
                    end
                end else begin
                    lo_d = lo_q + ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                hi_d    = '0;
                lo_d    = '0;
            end
        endcase

        // A fault outranks a simultaneous clear; clear outranks a good period
        if (fault) begin
            perr_d   = 1'b1;
            code_d   = fcode;
            sticky_d = 1'b1;
            lock_d   = '0;
            locked_d = 1'b0;
        end else if (clr) begin
            sticky_d = 1'b0;
            lock_d   = '0;
            locked_d = 1'b0;
        end else if (good) begin
            lock_d   = lock_inc;
            locked_d = (lock_inc == LOCK_N);
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            per_q    <= '0;
            high_q   <= '0;
            low_q    <= '0;
            vld_q    <= 1'b0;
            perr_q   <= 1'b0;
            code_q   <= 2'd0;
            sticky_q <= 1'b0;
            lock_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            per_q    <= per_d;
            high_q   <= high_d;
            low_q    <= low_d;
            vld_q    <= vld_d;
            perr_q   <= perr_d;
            code_q   <= code_d;
            sticky_q <= sticky_d;
            lock_q   <= lock_d;
            locked_q <= locked_d;
        end
    end

    assign period     = per_q;
    assign high_time  = high_q;
    assign low_time   = low_q;
    assign meas_vld   = vld_q;
    assign locked     = locked_q;
    assign err_pulse  = perr_q;
    assign err_code   = code_q;
    assign err_sticky = sticky_q;

endmodule
